// File: rtl/uart_tx_core_pkg.sv
// Shared types and helpers for the UART transmit core.
// State codes carry a Tx prefix so they cannot clash with the transmit-control FSM.
package uart_tx_core_pkg;

    typedef enum logic [2:0] {
        TxIdle   = 3'd0,
        TxStart  = 3'd1,
        TxData   = 3'd2,
        TxParity = 3'd3,
        TxStop   = 3'd4
    } tx_state_e;

    localparam int unsigned MaxDataW = 9;

    // Callers zero-extend narrower payloads; the padding does not change the XOR.
    function automatic logic frame_parity(input logic [MaxDataW-1:0] bits, input logic odd);
        return (^bits) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_core_baud_gen.sv
// Baud counter: while clr is low, tick pulses for one cycle every CLKS_PER_BIT cycles.
// Holding clr high keeps the count at zero.
module uart_tx_core_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = !clr && (cnt_q == CntLast);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_core.sv
// Serial transmitter: frames one byte per start_tr strobe as start, data (LSB first),
// optional parity and stop bits; busy_tr back-pressures the control FSM for the whole frame.
module uart_tx_core
    import uart_tx_core_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned DATA_W       = 8,
    parameter bit          PARITY_EN    = 1'b0,
    parameter bit          PARITY_ODD   = 1'b0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_tr,
    input  logic [DATA_W-1:0] data,
    output logic              tx,
    output logic              busy_tr
);

    localparam int unsigned BitW = $clog2(DATA_W + 1);
    localparam logic [BitW-1:0] LastData = BitW'(DATA_W - 1);
    localparam logic [BitW-1:0] LastStop = BitW'(STOP_BITS - 1);

    tx_state_e         state_q;
    logic [DATA_W-1:0] shift_q;
    logic [BitW-1:0]   bit_cnt_q;
    logic              parity_q;
    logic              tick;
    logic              baud_clr;

    // Holding the counter clear while idle lines the first tick up with the end of the start bit.
    assign baud_clr = (state_q == TxIdle);

    uart_tx_core_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (baud_clr),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= TxIdle;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            parity_q  <= 1'b0;
            tx        <= 1'b1;
            busy_tr   <= 1'b0;
        end else begin
            case (state_q)
                TxIdle: begin
                    if (start_tr) begin
                        shift_q   <= data;
                        parity_q  <= frame_parity(MaxDataW'(data), PARITY_ODD);
                        bit_cnt_q <= '0;
                        state_q   <= TxStart;
                        tx        <= 1'b0;
                        busy_tr   <= 1'b1;
                    end
                end
                TxStart: begin
                    if (tick) begin
                        state_q <= TxData;
                        tx      <= shift_q[0];
                    end
                end
                TxData: begin
                    if (tick) begin
                        shift_q <= shift_q >> 1;
                        if (bit_cnt_q == LastData) begin
                            bit_cnt_q <= '0;
                            if (PARITY_EN) begin
                                state_q <= TxParity;
                                tx      <= parity_q;
                            end else begin
                                state_q <= TxStop;
                                tx      <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx        <= shift_q[1];
                        end
                    end
                end
                TxParity: begin
                    if (tick) begin
                        state_q <= TxStop;
                        tx      <= 1'b1;
                    end
                end
                TxStop: begin
                    // The bit counter is reused to count stop bits.
                    if (tick) begin
                        if (bit_cnt_q == LastStop) begin
                            bit_cnt_q <= '0;
                            state_q   <= TxIdle;
                            busy_tr   <= 1'b0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= TxIdle;
                    tx      <= 1'b1;
                    busy_tr <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core: three configurations (plain, even parity, two stop bits)
// at four clocks per bit, plus a FIFO/control-FSM model driving back-to-back frames.
module tb_uart_tx_core;

    logic       clk;
    logic       rst_n;
    logic       start_a, start_p, start_s;
    logic [7:0] data_a, data_p, data_s;
    logic       tx_a, tx_p, tx_s;
    logic       busy_a, busy_p, busy_s;

    int vectors = 0;
    int errors  = 0;

    uart_tx_core #(.CLKS_PER_BIT(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .start_tr(start_a), .data(data_a), .tx(tx_a), .busy_tr(busy_a)
    );

    uart_tx_core #(.CLKS_PER_BIT(4), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
        .clk(clk), .rst_n(rst_n), .start_tr(start_p), .data(data_p), .tx(tx_p), .busy_tr(busy_p)
    );

    uart_tx_core #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start_tr(start_s), .data(data_s), .tx(tx_s), .busy_tr(busy_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({tx_a, busy_a, tx_p, busy_p, tx_s, busy_s} !== 6'b10_10_10) begin
            errors++;
            $display("FAIL reset_async: tx/busy a,p,s=%b expected 101010",
                     {tx_a, busy_a, tx_p, busy_p, tx_s, busy_s});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if ({tx_a, busy_a, tx_p, busy_p, tx_s, busy_s} !== 6'b10_10_10) begin
            errors++;
            $display("FAIL reset_idle: tx/busy a,p,s=%b expected 101010",
                     {tx_a, busy_a, tx_p, busy_p, tx_s, busy_s});
        end
    endtask

    task automatic test_basic();
        logic [9:0] exp;
        exp = {1'b1, 8'hA5, 1'b0};
        start_a = 1'b1; data_a = 8'hA5;
        @(posedge clk); #1;
        start_a = 1'b0; data_a = 8'h00;
        for (int c = 0; c < 40; c++) begin
            vectors++;
            if (tx_a !== exp[c/4] || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL basic_a5 cycle %0d: tx=%b busy=%b expected tx=%b busy=1",
                         c, tx_a, busy_a, exp[c/4]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_end: tx=%b busy=%b expected tx=1 busy=0", tx_a, busy_a);
        end
    endtask

    task automatic test_parity();
        logic [10:0] exp [2];
        logic [7:0]  din [2];
        din[0] = 8'hA5; exp[0] = {1'b1, 1'b0, 8'hA5, 1'b0};
        din[1] = 8'h07; exp[1] = {1'b1, 1'b1, 8'h07, 1'b0};
        for (int f = 0; f < 2; f++) begin
            start_p = 1'b1; data_p = din[f];
            @(posedge clk); #1;
            start_p = 1'b0;
            for (int c = 0; c < 44; c++) begin
                vectors++;
                if (tx_p !== exp[f][c/4] || busy_p !== 1'b1) begin
                    errors++;
                    $display("FAIL parity_%h cycle %0d: tx=%b busy=%b expected tx=%b busy=1",
                             din[f], c, tx_p, busy_p, exp[f][c/4]);
                end
                @(posedge clk); #1;
            end
            vectors++;
            if (tx_p !== 1'b1 || busy_p !== 1'b0) begin
                errors++;
                $display("FAIL parity_end_%h: tx=%b busy=%b expected tx=1 busy=0",
                         din[f], tx_p, busy_p);
            end
        end
    endtask

    task automatic test_two_stop();
        start_s = 1'b1; data_s = 8'h00;
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int c = 0; c < 44; c++) begin
            vectors++;
            if (tx_s !== (c >= 36) || busy_s !== 1'b1) begin
                errors++;
                $display("FAIL two_stop cycle %0d: tx=%b busy=%b expected tx=%b busy=1",
                         c, tx_s, busy_s, (c >= 36));
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (tx_s !== 1'b1 || busy_s !== 1'b0) begin
            errors++;
            $display("FAIL two_stop_end: tx=%b busy=%b expected tx=1 busy=0", tx_s, busy_s);
        end
    endtask

    task automatic test_ignored_and_back_to_back();
        logic [9:0] exp [2];
        exp[0] = {1'b1, 8'h3C, 1'b0};
        exp[1] = {1'b1, 8'hC3, 1'b0};
        start_a = 1'b1; data_a = 8'h3C;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int c = 0; c < 40; c++) begin
                vectors++;
                if (tx_a !== exp[f][c/4] || busy_a !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_frame%0d cycle %0d: tx=%b busy=%b expected tx=%b busy=1",
                             f, c, tx_a, busy_a, exp[f][c/4]);
                end
                // Mid-frame strobe and data change must have no effect.
                if (f == 0 && c == 10) begin start_a = 1'b1; data_a = 8'hFF; end
                if (f == 0 && c == 11) start_a = 1'b0;
                @(posedge clk); #1;
            end
            vectors++;
            if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL b2b_end%0d: tx=%b busy=%b expected tx=1 busy=0", f, tx_a, busy_a);
            end
            if (f == 0) begin
                start_a = 1'b1; data_a = 8'hC3;
                @(posedge clk); #1;
                start_a = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp;
        exp = {1'b1, 8'h5A, 1'b0};
        start_a = 1'b1; data_a = 8'hF0;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        vectors++;
        if (tx_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_frame: tx=%b busy=%b expected tx=1 busy=0", tx_a, busy_a);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b1; data_a = 8'h5A;
        @(posedge clk); #1;
        start_a = 1'b0;
        for (int c = 0; c < 40; c++) begin
            vectors++;
            if (tx_a !== exp[c/4] || busy_a !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_5a cycle %0d: tx=%b busy=%b expected tx=%b busy=1",
                         c, tx_a, busy_a, exp[c/4]);
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_end: busy=%b expected 0", busy_a);
        end
    endtask

    task automatic test_integration();
        logic [7:0] fifo [3];
        logic       q [$];
        logic [7:0] got;
        int rd, reads, n, last, i;
        fifo[0] = 8'h11; fifo[1] = 8'h22; fifo[2] = 8'h33;
        rd = 0; reads = 0;
        // Control FSM model: one FIFO read and start strobe whenever the core is free.
        for (int c = 0; c < 140; c++) begin
            q.push_back(tx_a);
            if (!busy_a && !start_a && rd < 3) begin
                start_a = 1'b1; data_a = fifo[rd]; rd++; reads++;
            end else begin
                start_a = 1'b0;
            end
            @(posedge clk); #1;
        end
        start_a = 1'b0;
        n = 0; last = 0; i = 0;
        while (i < q.size()) begin
            if (q[i] == 1'b0 && i + 40 <= q.size()) begin
                for (int b = 0; b < 8; b++) got[b] = q[i + 4*(b+1) + 2];
                vectors++;
                if (n >= 3 || got !== fifo[n]) begin
                    errors++;
                    $display("FAIL integ_byte%0d: got %h expected %h", n, got,
                             (n < 3) ? fifo[n] : 8'hxx);
                end
                vectors++;
                if (q[i + 38] !== 1'b1) begin
                    errors++;
                    $display("FAIL integ_stop%0d: stop=%b expected 1", n, q[i + 38]);
                end
                if (n > 0) begin
                    vectors++;
                    if (i - last !== 41) begin
                        errors++;
                        $display("FAIL integ_spacing%0d: %0d cycles expected 41", n, i - last);
                    end
                end
                last = i; n++; i += 40;
            end else begin
                i++;
            end
        end
        vectors++;
        if (n !== 3) begin
            errors++;
            $display("FAIL integ_frames: %0d frames expected 3", n);
        end
        vectors++;
        if (reads !== n) begin
            errors++;
            $display("FAIL integ_reads: %0d reads for %0d frames", reads, n);
        end
    endtask

    initial begin
        start_a = 1'b0; start_p = 1'b0; start_s = 1'b0;
        data_a = 8'h00; data_p = 8'h00; data_s = 8'h00;
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_ignored_and_back_to_back();
        test_reset_mid_frame();
        test_integration();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
